// File: rtl/ieee1355_pkg.sv
// Shared IEEE1355 DS-link definitions: character format, NULL pattern,
// receiver alignment states and the DS transmit encoding rule.
package ieee1355_pkg;

    localparam int unsigned C_CHAR_BITS = 10;
    localparam logic [C_CHAR_BITS-1:0] C_NULL_CHAR = 10'b1111000110;

    typedef logic [C_CHAR_BITS-1:0] ds_char_t;

    typedef enum logic {
        HUNT    = 1'b0,
        ALIGNED = 1'b1
    } align_state_t;

    // Strobe toggles exactly when data repeats, so one line changes per bit.
    function automatic logic ds_strobe_next(input logic d_prev, input logic s_prev,
                                            input logic d_next);
        return (d_next == d_prev) ? ~s_prev : s_prev;
    endfunction

endpackage

// File: rtl/ieee1355_ds_rx_if.sv
// Character handshake from the DS receiver to its consumer.
interface ieee1355_ds_rx_if;
    import ieee1355_pkg::*;

    ds_char_t rx_data;
    logic     rx_valid;
    logic     rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/ieee1355_ds_sync.sv
// Two-flop synchroniser for D and S plus registered transition detect.
// bit_evt/bit_val/ds_err describe the transition between stages 2 and 3.
module ieee1355_ds_sync (
    input  logic clk_x4,
    input  logic rst_n,
    input  logic d_in,
    input  logic s_in,
    output logic bit_evt,
    output logic bit_val,
    output logic ds_err
);

    logic d_s1, d_s2, d_s3;
    logic s_s1, s_s2, s_s3;

    always_ff @(posedge clk_x4 or negedge rst_n) begin
        if (!rst_n) begin
            d_s1    <= 1'b0;
            d_s2    <= 1'b0;
            d_s3    <= 1'b0;
            s_s1    <= 1'b0;
            s_s2    <= 1'b0;
            s_s3    <= 1'b0;
            bit_evt <= 1'b0;
            bit_val <= 1'b0;
            ds_err  <= 1'b0;
        end else begin
            d_s1    <= d_in;
            d_s2    <= d_s1;
            d_s3    <= d_s2;
            s_s1    <= s_in;
            s_s2    <= s_s1;
            s_s3    <= s_s2;
            bit_evt <= (d_s2 ^ d_s3) | (s_s2 ^ s_s3);
            bit_val <= d_s2;
            ds_err  <= (d_s2 ^ d_s3) & (s_s2 ^ s_s3);
        end
    end

endmodule

// File: rtl/ieee1355_ds_rx.sv
// DS-link receiver: NULL alignment, character framing, disconnect timeout
// and a one-entry valid/ready output register.
module ieee1355_ds_rx
    import ieee1355_pkg::*;
#(
    parameter int unsigned G_CHAR_BITS    = C_CHAR_BITS,
    parameter ds_char_t    G_NULL_CHAR    = C_NULL_CHAR,
    parameter int unsigned G_DISC_TIMEOUT = 32,
    parameter int unsigned G_TIMEOUT_W    = 6
) (
    input  logic             clk_x4,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             s_in,
    ieee1355_ds_rx_if.master rx,
    output logic             link_up,
    output logic             null_pulse,
    output logic             ds_err,
    output logic             overrun,
    output logic             disconnect
);

    localparam int unsigned CNT_W = $clog2(G_CHAR_BITS);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(G_CHAR_BITS - 1);
    localparam logic [G_TIMEOUT_W-1:0] TMO_MAX  = G_TIMEOUT_W'(G_DISC_TIMEOUT);
    localparam logic [G_TIMEOUT_W-1:0] TMO_LAST = G_TIMEOUT_W'(G_DISC_TIMEOUT - 1);

    logic bit_evt, bit_val;

    align_state_t           state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [G_TIMEOUT_W-1:0] tmo_q, tmo_d;
    ds_char_t               sr_q, sr_d, sr_shift;
    ds_char_t               rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   link_up_d, null_d, overrun_d, disc_d;
    logic                   char_done;

    ieee1355_ds_sync u_sync (
        .clk_x4  (clk_x4),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .s_in    (s_in),
        .bit_evt (bit_evt),
        .bit_val (bit_val),
        .ds_err  (ds_err)
    );

    assign sr_shift    = {bit_val, sr_q[C_CHAR_BITS-1:1]};
    assign rx.rx_data  = rx_data_q;
    assign rx.rx_valid = rx_valid_q;

    // Next-state: alignment FSM, bit counter, timeout and output register.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_d      = tmo_q;
        sr_d       = sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        link_up_d  = link_up;
        null_d     = 1'b0;
        overrun_d  = 1'b0;
        disc_d     = 1'b0;
        char_done  = 1'b0;

        if (rx_valid_q && rx.rx_ready) rx_valid_d = 1'b0;

        if (bit_evt) begin
            tmo_d = '0;
            sr_d  = sr_shift;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + G_TIMEOUT_W'(1);
        end

        case (state_q)
            HUNT: begin
                if (bit_evt && sr_shift == G_NULL_CHAR) begin
                    state_d   = ALIGNED;
                    bit_cnt_d = '0;
                    null_d    = 1'b1;
                    link_up_d = 1'b1;
                end
            end
            ALIGNED: begin
                if (bit_evt) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (sr_shift == G_NULL_CHAR) null_d = 1'b1;
                        else                         char_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Partial character is abandoned; a held output stays valid.
                    state_d   = HUNT;
                    bit_cnt_d = '0;
                    link_up_d = 1'b0;
                    disc_d    = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (char_done) begin
            if (!rx_valid_q || rx.rx_ready) begin
                rx_data_d  = sr_shift;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_x4 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            sr_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            link_up    <= 1'b0;
            null_pulse <= 1'b0;
            overrun    <= 1'b0;
            disconnect <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            sr_q       <= sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            link_up    <= link_up_d;
            null_pulse <= null_d;
            overrun    <= overrun_d;
            disconnect <= disc_d;
        end
    end

endmodule
